// File: rtl/sha256_block_sequencer.sv
// -----------------------------------------------------------------------------
// sha256_block_sequencer
//
// Purpose:
//   Accepts a message as a stream of 32-bit big-endian words and turns it into
//   a sequence of padded 512-bit SHA-256 blocks. Each block is handed to an
//   external compression core together with the chaining hash. The core's
//   result becomes the chaining hash for the next block. When the last block
//   completes, the result is published as the message digest.
//
//   Padding is generated here. It consists of the 0x80000000 marker word, then
//   zero words, then the 64-bit message bit length in words 14/15. If the
//   marker lands in word 14 or 15, an extra block that holds only the length
//   is produced.
//
// Parameters:
//   CNT_W         width of the message word counter (wraps modulo 2^CNT_W)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset_n       asynchronous active-low reset
//   in_data       message word, big-endian byte order
//   in_valid      in_data valid
//   in_last       marks the final word of a message (qualified by in_valid)
//   in_ready      registered; high only while the sequencer fills a block
//   core_start    one-cycle start pulse to the compression core
//   core_done     core idle / result-valid level
//   core_block    512-bit block to the core; word 0 sits in bits [511:480]
//   core_hash     chaining hash seed to the core; H0 sits in bits [255:224]
//   core_digest   core result (seed + compressed state), same packing
//   digest        final message digest, held until the next message completes
//   digest_valid  one-cycle pulse when digest has been updated
// -----------------------------------------------------------------------------
module sha256_block_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [31:0]  in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic         core_start,
   input  logic         core_done,
   output logic [511:0] core_block,
   output logic [255:0] core_hash,
   input  logic [255:0] core_digest,
   output logic [255:0] digest,
   output logic         digest_valid
);

   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] PAD_MARKER = 32'h80000000;
   localparam logic [31:0] ZERO_WORD  = 32'h00000000;
   localparam logic [3:0]  IDX_LEN_HI = 4'd14;
   localparam logic [3:0]  IDX_LEN_LO = 4'd15;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_PAD     = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT_LO = 3'd4,
      ST_WAIT_HI = 3'd5
   } state_t;

   // Replace word 'idx' (0 = most significant word) of a 512-bit block.
   function automatic logic [511:0] put_word(input logic [511:0] blk,
                                             input logic [3:0]   idx,
                                             input logic [31:0]  word);
      logic [511:0] res;
      res = blk;
      res[32 * (15 - int'(idx)) +: 32] = word;
      return res;
   endfunction

   // Message length in bits as the 64-bit field SHA-256 appends to the message.
   function automatic logic [63:0] bit_length(input logic [CNT_W-1:0] words);
      logic [63:0] len;
      len = 64'(words) << 5;
      return len;
   endfunction

   state_t         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [511:0]   block_q, block_d;
   logic [255:0]   hash_q, hash_d;
   logic [255:0]   digest_q, digest_d;
   logic           digest_valid_q, digest_valid_d;
   logic           start_q, start_d;
   logic           ready_q, ready_d;
   // Block currently being issued ends the message.
   logic           final_q, final_d;
   // Message input has ended; the remaining blocks are padding.
   logic           padding_q, padding_d;
   // The 0x80000000 marker has not been written yet.
   logic           mark_q, mark_d;
   // The marker landed in word 14/15, so this block cannot carry the length.
   logic           spill_q, spill_d;
   logic [63:0]    len_bits_s;
   logic [31:0]    pad_word_s;

   assign len_bits_s = bit_length(cnt_q);

   // Select the word that PAD writes at the current index.
   always_comb begin
      pad_word_s = ZERO_WORD;
      if (mark_q) begin
         pad_word_s = PAD_MARKER;
      end else if (idx_q == IDX_LEN_HI) begin
         pad_word_s = spill_q ? ZERO_WORD : len_bits_s[63:32];
      end else if (idx_q == IDX_LEN_LO) begin
         pad_word_s = spill_q ? ZERO_WORD : len_bits_s[31:0];
      end else begin
         pad_word_s = ZERO_WORD;
      end
   end

   // Compute the next-state logic for the sequencer FSM and its datapath.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      block_d        = block_q;
      hash_d         = hash_q;
      digest_d       = digest_q;
      digest_valid_d = 1'b0;
      final_d        = final_q;
      padding_d      = padding_q;
      mark_d         = mark_q;
      spill_d        = spill_q;

      case (state_q)
         ST_IDLE: begin
            // A new message always starts from the IV with an empty counter.
            state_d   = ST_FILL;
            idx_d     = 4'd0;
            cnt_d     = {CNT_W{1'b0}};
            hash_d    = SHA256_IV;
            final_d   = 1'b0;
            padding_d = 1'b0;
            mark_d    = 1'b0;
            spill_d   = 1'b0;
         end

         ST_FILL: begin
            if (in_valid && ready_q) begin
               block_d = put_word(block_q, idx_q, in_data);
               cnt_d   = cnt_q + CNT_ONE;
               idx_d   = idx_q + 4'd1;
               if (in_last) begin
                  padding_d = 1'b1;
                  mark_d    = 1'b1;
                  // A full block is issued first; padding resumes at word 0.
                  if (idx_q == 4'd15) begin
                     final_d = 1'b0;
                     state_d = ST_ISSUE;
                  end else begin
                     state_d = ST_PAD;
                  end
               end else if (idx_q == 4'd15) begin
                  final_d = 1'b0;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_FILL;
            end
         end

         ST_PAD: begin
            block_d = put_word(block_q, idx_q, pad_word_s);
            idx_d   = idx_q + 4'd1;
            if (mark_q) begin
               mark_d  = 1'b0;
               spill_d = (idx_q >= IDX_LEN_HI);
            end else begin
               spill_d = spill_q;
            end
            if (idx_q == IDX_LEN_LO) begin
               // The block is final only if it carried the length field.
               final_d = !(mark_q || spill_q);
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_PAD;
            end
         end

         ST_ISSUE: begin
            state_d = ST_WAIT_LO;
         end

         ST_WAIT_LO: begin
            // Wait for the core to leave its idle level before trusting done.
            if (!core_done) begin
               state_d = ST_WAIT_HI;
            end else begin
               state_d = ST_WAIT_LO;
            end
         end

         ST_WAIT_HI: begin
            if (core_done) begin
               hash_d = core_digest;
               idx_d  = 4'd0;
               if (final_q) begin
                  digest_d       = core_digest;
                  digest_valid_d = 1'b1;
                  state_d        = ST_IDLE;
               end else if (padding_q) begin
                  spill_d = 1'b0;
                  state_d = ST_PAD;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               state_d = ST_WAIT_HI;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered handshake/strobe outputs follow the state being entered.
   always_comb begin
      ready_d = (state_d == ST_FILL);
      start_d = (state_d == ST_ISSUE);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= 4'd0;
         cnt_q          <= {CNT_W{1'b0}};
         block_q        <= 512'd0;
         hash_q         <= SHA256_IV;
         digest_q       <= 256'd0;
         digest_valid_q <= 1'b0;
         start_q        <= 1'b0;
         ready_q        <= 1'b0;
         final_q        <= 1'b0;
         padding_q      <= 1'b0;
         mark_q         <= 1'b0;
         spill_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         block_q        <= block_d;
         hash_q         <= hash_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
         start_q        <= start_d;
         ready_q        <= ready_d;
         final_q        <= final_d;
         padding_q      <= padding_d;
         mark_q         <= mark_d;
         spill_q        <= spill_d;
      end
   end

   assign in_ready     = ready_q;
   assign core_start   = start_q;
   assign core_block   = block_q;
   assign core_hash    = hash_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;

endmodule
